// File: rtl/line_buffer_reader.sv
// Small register-based FIFO for valid/ready buffering. Head is visible in the cycle after the push.
// The caller reserves space before pushing: there is no full flag and no push backpressure.
module lbr_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         push_vld,
  input  logic [WIDTH-1:0]             push_dat,
  input  logic                         pop_rdy,
  output logic                         head_vld,
  output logic [WIDTH-1:0]             head_dat,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             pop;

  assign head_vld = (count != '0);
  assign pop      = head_vld && pop_rdy;
  assign head_dat = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push_vld) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= (wr_ptr == AW'(DEPTH-1)) ? '0 : wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= (rd_ptr == AW'(DEPTH-1)) ? '0 : rd_ptr + 1'b1;
      count <= count + CW'(push_vld) - CW'(pop);
    end
  end
endmodule

// Pops all row FIFOs in lockstep and streams tagged pixel columns; read-to-valid latency is 2 cycles.
// A 2-entry output buffer absorbs consumer stalls; reads stop once buffer plus in-flight reads reach 2.
module line_buffer_reader #(
  parameter int FIFO_DATA_WIDTH      = 8,
  parameter int FIFO_COMPONENT_COUNT = 6,
  parameter int FRAME_WIDTH          = 10,
  parameter int FRAME_HEIGHT         = 10,
  parameter int BYTE_DOUBLE_WIDTH    = 16
) (
  input  logic                                            clk,
  input  logic                                            reset_n,
  input  logic                                            i_enable,
  input  logic [FIFO_COMPONENT_COUNT-1:0]                 i_fifo_empty,
  input  logic [FIFO_COMPONENT_COUNT*FIFO_DATA_WIDTH-1:0] i_fifo_data,
  output logic [FIFO_COMPONENT_COUNT-1:0]                 o_fifo_rd,
  output logic                                            o_valid,
  input  logic                                            i_ready,
  output logic [FIFO_COMPONENT_COUNT*FIFO_DATA_WIDTH-1:0] o_column,
  output logic [BYTE_DOUBLE_WIDTH-1:0]                    o_xcoord,
  output logic [BYTE_DOUBLE_WIDTH-1:0]                    o_ycoord,
  output logic                                            o_eol,
  output logic                                            o_eof,
  output logic                                            o_busy
);
  localparam int COL_W = FIFO_COMPONENT_COUNT * FIFO_DATA_WIDTH;
  localparam int BW    = BYTE_DOUBLE_WIDTH;
  localparam logic [BW-1:0] X_LAST = BW'(FRAME_WIDTH - 1);
  localparam logic [BW-1:0] Y_LAST = BW'(FRAME_HEIGHT - FIFO_COMPONENT_COUNT);

  typedef enum logic [1:0] {IDLE = 2'd0, STREAM = 2'd1, DRAIN = 2'd2} state_t;

  state_t        state;
  logic          busy_q;
  logic          rd_inflight;
  logic          rd_issue;
  logic          rows_vld;
  logic          col_vld;
  logic          xfer;
  logic [1:0]    buf_count;
  logic [2:0]    committed;
  logic [BW-1:0] x_cnt;
  logic [BW-1:0] y_cnt;
  logic          x_last;
  logic          y_last;

  // A slot freed by this cycle's transfer can be reused at once, which keeps one column per cycle.
  assign xfer      = col_vld && i_ready;
  assign committed = 3'(buf_count) + 3'(rd_inflight) - 3'(xfer);
  assign rows_vld  = (i_fifo_empty == '0);
  assign rd_issue  = (state == STREAM) && rows_vld && (committed < 3'd2);
  assign o_fifo_rd = {FIFO_COMPONENT_COUNT{rd_issue}};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rd_inflight <= 1'b0;
    else          rd_inflight <= rd_issue;
  end

  lbr_fifo #(
    .WIDTH (COL_W),
    .DEPTH (2)
  ) u_col_buf (
    .clk      (clk),
    .reset_n  (reset_n),
    .push_vld (rd_inflight),
    .push_dat (i_fifo_data),
    .pop_rdy  (i_ready),
    .head_vld (col_vld),
    .head_dat (o_column),
    .count    (buf_count)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      busy_q <= 1'b0;
    end else begin
      case (state)
        IDLE: if (i_enable) begin
          state  <= STREAM;
          busy_q <= 1'b1;
        end
        STREAM: if (!i_enable) state <= DRAIN;
        DRAIN: begin
          if (i_enable) begin
            state <= STREAM;
          end else if (!rd_inflight && buf_count == 2'd0) begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  // Coordinates track the column at the buffer head, so they only move on a transfer.
  assign x_last = (x_cnt == X_LAST);
  assign y_last = (y_cnt == Y_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      x_cnt <= '0;
      y_cnt <= '0;
    end else if (xfer) begin
      if (x_last) begin
        x_cnt <= '0;
        y_cnt <= y_last ? '0 : y_cnt + 1'b1;
      end else begin
        x_cnt <= x_cnt + 1'b1;
      end
    end
  end

  assign o_valid  = col_vld;
  assign o_xcoord = x_cnt;
  assign o_ycoord = y_cnt;
  assign o_eol    = col_vld && x_last;
  assign o_eof    = o_eol && y_last;
  assign o_busy   = busy_q;
endmodule

// File: tb/tb_line_buffer_reader.sv
// Bench for line_buffer_reader: row FIFOs modelled as queues, expected columns scoreboarded,
// coordinates derived from the transfer index since reset.
module tb_line_buffer_reader;
  localparam int DW = 8;
  localparam int N  = 6;
  localparam int FW = 10;
  localparam int FH = 10;
  localparam int BW = 16;
  localparam int CW = N * DW;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          i_enable;
  logic          i_ready;
  logic [N-1:0]  i_fifo_empty;
  logic [N-1:0]  o_fifo_rd;
  logic [CW-1:0] i_fifo_data;
  logic [CW-1:0] o_column;
  logic          o_valid;
  logic          o_eol;
  logic          o_eof;
  logic          o_busy;
  logic [BW-1:0] o_xcoord;
  logic [BW-1:0] o_ycoord;

  always #5 clk = ~clk;

  line_buffer_reader #(
    .FIFO_DATA_WIDTH      (DW),
    .FIFO_COMPONENT_COUNT (N),
    .FRAME_WIDTH          (FW),
    .FRAME_HEIGHT         (FH),
    .BYTE_DOUBLE_WIDTH    (BW)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .i_enable     (i_enable),
    .i_fifo_empty (i_fifo_empty),
    .i_fifo_data  (i_fifo_data),
    .o_fifo_rd    (o_fifo_rd),
    .o_valid      (o_valid),
    .i_ready      (i_ready),
    .o_column     (o_column),
    .o_xcoord     (o_xcoord),
    .o_ycoord     (o_ycoord),
    .o_eol        (o_eol),
    .o_eof        (o_eof),
    .o_busy       (o_busy)
  );

  logic [DW-1:0] rowq [N][$];
  logic [CW-1:0] exp_q [$];

  int n_checks = 0;
  int n_pass   = 0;
  int n_xfer   = 0;
  int n_rd     = 0;
  int n_tick   = 0;
  int n_eof    = 0;
  logic [N-1:0] s_rd;
  logic         s_vld;

  // monitor state
  int            mon_k = 0;
  logic          mon_held = 1'b0;
  logic [CW-1:0] mon_col;
  logic [BW-1:0] mon_x;
  logic [BW-1:0] mon_y;
  logic [CW-1:0] mon_exp;
  int            mon_ex;
  int            mon_ey;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", name, act, exp);
  endtask

  function automatic void update_empty();
    for (int r = 0; r < N; r++) i_fifo_empty[r] = (rowq[r].size() == 0);
  endfunction

  function automatic logic [CW-1:0] rand_col();
    logic [CW-1:0] c;
    for (int r = 0; r < N; r++) c[r*DW +: DW] = DW'($urandom);
    return c;
  endfunction

  task automatic push_col(input logic [CW-1:0] c);
    for (int r = 0; r < N; r++) rowq[r].push_back(c[r*DW +: DW]);
    exp_q.push_back(c);
    update_empty();
  endtask

  // One clock: sample DUT at negedge, then act as the row FIFOs (1-cycle read latency).
  task automatic tick();
    @(negedge clk);
    s_rd  = o_fifo_rd;
    s_vld = o_valid;
    n_tick++;
    @(posedge clk);
    #1;
    if (s_rd != '0) begin
      n_rd++;
      check("rd_lockstep", 64'(s_rd), 64'({N{1'b1}}));
      for (int r = 0; r < N; r++) begin
        check("rd_row_nonempty", 64'(rowq[r].size() != 0), 64'd1);
        if (rowq[r].size() != 0) i_fifo_data[r*DW +: DW] = rowq[r].pop_front();
      end
    end
    update_empty();
  endtask

  task automatic drain(input string name, input int budget);
    int t = 0;
    i_ready = 1'b1;
    while (exp_q.size() != 0 && t < budget) begin
      tick();
      t++;
    end
    check(name, 64'(exp_q.size()), 64'd0);
  endtask

  // Monitor: compares each transfer against the scoreboard and the coordinate model.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        mon_k    = 0;
        mon_held = 1'b0;
      end else begin
        if (mon_held) begin
          check("hold_valid", 64'(o_valid), 64'd1);
          check("hold_column", 64'(o_column), 64'(mon_col));
          check("hold_xy", 64'({o_xcoord, o_ycoord}), 64'({mon_x, mon_y}));
        end
        if (o_valid && i_ready) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_column: got %0h want none", o_column);
          end else begin
            mon_exp = exp_q.pop_front();
            mon_ex  = mon_k % FW;
            mon_ey  = (mon_k / FW) % (FH - N + 1);
            check("column", 64'(o_column), 64'(mon_exp));
            check("xcoord", 64'(o_xcoord), 64'(mon_ex));
            check("ycoord", 64'(o_ycoord), 64'(mon_ey));
            check("eol", 64'(o_eol), 64'(mon_ex == FW - 1));
            check("eof", 64'(o_eof), 64'(mon_ex == FW - 1 && mon_ey == FH - N));
          end
          if (o_eof) n_eof++;
          mon_k++;
          n_xfer++;
        end
        mon_held = o_valid && !i_ready;
        mon_col  = o_column;
        mon_x    = o_xcoord;
        mon_y    = o_ycoord;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    int first_rd;
    int first_vld;
    int rd0;
    int x0;
    int t;
    int pushed;
    logic [CW-1:0] c;
    logic [CW-1:0] sc [2];

    reset_n     = 1'b0;
    i_enable    = 1'b0;
    i_ready     = 1'b0;
    i_fifo_data = '0;
    update_empty();
    repeat (3) tick();
    check("rst_valid", 64'(o_valid), 64'd0);
    check("rst_rd", 64'(o_fifo_rd), 64'd0);
    check("rst_x", 64'(o_xcoord), 64'd0);
    check("rst_y", 64'(o_ycoord), 64'd0);
    check("rst_busy", 64'(o_busy), 64'd0);
    check("rst_flags", 64'({o_eol, o_eof}), 64'd0);
    check("rst_column", 64'(o_column), 64'd0);
    reset_n = 1'b1;

    // Prime with row r pixel x = 10*r + x.
    for (int x = 0; x < FW; x++) begin
      for (int r = 0; r < N; r++) c[r*DW +: DW] = DW'(10 * r + x);
      push_col(c);
    end
    i_enable  = 1'b1;
    i_ready   = 1'b1;
    first_rd  = -1;
    first_vld = -1;
    repeat (16) begin
      tick();
      if (first_rd < 0 && s_rd != '0) first_rd = n_tick;
      if (first_vld < 0 && s_vld) first_vld = n_tick;
    end
    check("prime_latency", 64'(first_vld - first_rd), 64'd2);
    check("prime_throughput", 64'(n_xfer), 64'd10);

    // Row 3 starved: nothing may be read from any row.
    sc[0] = rand_col();
    sc[1] = rand_col();
    for (int i = 0; i < 2; i++)
      for (int r = 0; r < N; r++)
        if (r != 3) rowq[r].push_back(sc[i][r*DW +: DW]);
    update_empty();
    repeat (6) begin
      tick();
      check("starve_rd", 64'(s_rd), 64'd0);
      check("starve_vld", 64'(s_vld), 64'd0);
    end
    rd0 = n_rd;
    for (int i = 0; i < 2; i++) begin
      rowq[3].push_back(sc[i][3*DW +: DW]);
      exp_q.push_back(sc[i]);
    end
    update_empty();
    repeat (8) tick();
    check("starve_resume_rd", 64'(n_rd - rd0), 64'd2);
    check("starve_resume_xfer", 64'(n_xfer), 64'd12);

    // Backpressure mid-line.
    repeat (20) push_col(rand_col());
    repeat (6) tick();
    i_ready = 1'b0;
    rd0 = n_rd;
    repeat (5) begin
      tick();
      check("bp_vld_hold", 64'(s_vld), 64'd1);
    end
    check("bp_no_rd", 64'(n_rd - rd0), 64'd0);
    i_ready = 1'b1;
    repeat (4) begin
      tick();
      check("bp_resume_vld", 64'(s_vld), 64'd1);
    end
    drain("bp_drain", 100);

    // Random data, sparse FIFO fill and random ready across two frame wraps.
    pushed = 0;
    t = 0;
    while ((pushed < 70 || exp_q.size() != 0) && t < 2000) begin
      if (pushed < 70 && $urandom_range(0, 2) != 0) begin
        push_col(rand_col());
        pushed++;
      end
      i_ready = ($urandom_range(0, 3) != 0);
      tick();
      t++;
    end
    check("frame_done", 64'(exp_q.size()), 64'd0);
    check("eof_count", 64'(n_eof), 64'd2);

    // Disable with one column buffered and one read in flight.
    i_ready = 1'b1;
    repeat (8) push_col(rand_col());
    repeat (4) tick();
    i_enable = 1'b0;
    i_ready  = 1'b0;
    x0  = n_xfer;
    rd0 = n_rd;
    repeat (3) tick();
    i_ready = 1'b1;
    t = 0;
    while (o_busy && t < 20) begin
      tick();
      t++;
    end
    check("dis_no_rd", 64'(n_rd - rd0), 64'd0);
    check("dis_xfer", 64'(n_xfer - x0), 64'd2);
    check("dis_busy", 64'(o_busy), 64'd0);

    // Async reset while a column is held and a read is in flight.
    repeat (4) push_col(rand_col());
    i_enable = 1'b1;
    i_ready  = 1'b0;
    t = 0;
    while (!o_valid && t < 10) begin
      tick();
      t++;
    end
    check("pre_reset_vld", 64'(o_valid), 64'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_valid", 64'(o_valid), 64'd0);
    check("arst_rd", 64'(o_fifo_rd), 64'd0);
    check("arst_xy", 64'({o_xcoord, o_ycoord}), 64'd0);
    check("arst_busy", 64'(o_busy), 64'd0);
    for (int r = 0; r < N; r++) rowq[r].delete();
    exp_q.delete();
    update_empty();
    repeat (2) tick();
    reset_n = 1'b1;
    i_ready = 1'b1;
    repeat (5) begin
      tick();
      check("post_reset_vld", 64'(s_vld), 64'd0);
    end
    repeat (3) push_col(rand_col());
    drain("post_reset_drain", 50);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
